bit_deserializer: RTL

BIT_DESERIALIZER -- requirements
Module: bit_deserializer

---
 rtl/bit_deserializer_pkg.sv | 12 +
 rtl/bit_deserializer.sv | 103 ++++++++++
 2 files changed

// File: rtl/bit_deserializer_pkg.sv
// Shared types and constants for the serial-to-parallel word assembler.
// Parity support in bit_deserializer is enabled by BIT_DESERIALIZER_PARITY_EN.
package deser_pkg;

  localparam int DESER_DEFAULT_WIDTH = 8;

  typedef enum logic {
    ST_DATA   = 1'b0,
    ST_PARITY = 1'b1
  } deser_state_t;

endpackage

// File: rtl/bit_deserializer.sv
// Serial bit stream to WIDTH-bit word assembler with a one-deep valid/ready output.
// Define BIT_DESERIALIZER_PARITY_EN to expect a trailing even-parity bit per word.
//
// state     | meaning
// ----------+-------------------------------------------------
// ST_DATA   | collecting the WIDTH data bits of a word
// ST_PARITY | data complete, waiting for the parity bit
module bit_deserializer
  import deser_pkg::*;
#(
  parameter int WIDTH     = DESER_DEFAULT_WIDTH,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_in,
  input  logic             bit_vld,
  output logic [WIDTH-1:0] word_out,
  output logic             word_vld,
  input  logic             word_rdy,
  output logic             busy,
  output logic             ovf,
  input  logic             ovf_clr
`ifdef BIT_DESERIALIZER_PARITY_EN
  , output logic           parity_err
`endif
);

  localparam int            CW        = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_DATA = CW'(WIDTH - 1);

  deser_state_t     state;
  logic [CW-1:0]    bit_cnt;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_nxt;
  logic [WIDTH-1:0] word_new;
  logic             data_last;
  logic             word_done;
  logic             hold;

  always_comb begin
    shreg_nxt = shreg;
    if (MSB_FIRST != 0) shreg_nxt = {shreg[WIDTH-2:0], bit_in};
    else                shreg_nxt = {bit_in, shreg[WIDTH-1:1]};
  end

  assign data_last = bit_vld && (state == ST_DATA) && (bit_cnt == LAST_DATA);
  assign hold      = word_vld && !word_rdy;
  assign busy      = (bit_cnt != '0);

`ifdef BIT_DESERIALIZER_PARITY_EN
  logic par_acc;
  // Data bits are already in shreg when the parity bit arrives.
  assign word_done = bit_vld && (state == ST_PARITY);
  assign word_new  = shreg;
`else
  assign word_done = data_last;
  assign word_new  = shreg_nxt;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_DATA;
      bit_cnt  <= '0;
      shreg    <= '0;
      word_out <= '0;
      word_vld <= 1'b0;
      ovf      <= 1'b0;
`ifdef BIT_DESERIALIZER_PARITY_EN
      par_acc    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      if (bit_vld) begin
        if (state == ST_DATA) shreg <= shreg_nxt;
        if (word_done) bit_cnt <= '0;
        else           bit_cnt <= bit_cnt + 1'b1;
      end

`ifdef BIT_DESERIALIZER_PARITY_EN
      if (data_last)      state <= ST_PARITY;
      else if (word_done) state <= ST_DATA;
      if (bit_vld && (state == ST_DATA))
        par_acc <= (bit_cnt == '0) ? bit_in : (par_acc ^ bit_in);
`endif

      // A completing word replaces the held one only if the held one leaves this cycle.
      if (word_done && !hold) begin
        word_out <= word_new;
        word_vld <= 1'b1;
`ifdef BIT_DESERIALIZER_PARITY_EN
        parity_err <= par_acc ^ bit_in;
`endif
      end else if (word_vld && word_rdy) begin
        word_vld <= 1'b0;
      end

      if (word_done && hold) ovf <= 1'b1;
      else if (ovf_clr)      ovf <= 1'b0;
    end
  end

endmodule
